// File: rtl/spi_frame_pkg.sv
// Shared constants and state encoding for the SPI frame controller.
// Default frame/timeout values are the production settings.
package spi_frame_pkg;

    localparam int FRAME_BITS_DEF     = 256;
    localparam int CNT_W_DEF          = 9;
    localparam int TIMEOUT_CYCLES_DEF = 5000000;
    localparam int WD_W_DEF           = 23;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CHECK = 2'd2
    } state_e;

endpackage

// File: rtl/spi_input_sync.sv
// Brings the asynchronous SPI pins into the CLK domain.
// Edge pulses are combinational on the synchronised level and its one-cycle-old copy.
module spi_input_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic sclk,
    input  logic cs_n,
    input  logic mosi,
    output logic mosi_sync,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic cs_rise,
    output logic cs_fall
);

    logic sclk_p0, sclk_p1, sclk_p2;
    logic cs_p0, cs_p1, cs_p2;
    logic mosi_p0, mosi_p1;

    // CS_N resets high so releasing reset never looks like a frame start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_p0 <= 1'b0;
            sclk_p1 <= 1'b0;
            sclk_p2 <= 1'b0;
            cs_p0   <= 1'b1;
            cs_p1   <= 1'b1;
            cs_p2   <= 1'b1;
            mosi_p0 <= 1'b0;
            mosi_p1 <= 1'b0;
        end else begin
            sclk_p0 <= sclk;
            sclk_p1 <= sclk_p0;
            sclk_p2 <= sclk_p1;
            cs_p0   <= cs_n;
            cs_p1   <= cs_p0;
            cs_p2   <= cs_p1;
            mosi_p0 <= mosi;
            mosi_p1 <= mosi_p0;
        end
    end

    assign mosi_sync = mosi_p1;
    assign sclk_rise = sclk_p1 & ~sclk_p2;
    assign sclk_fall = ~sclk_p1 & sclk_p2;
    assign cs_rise   = cs_p1 & ~cs_p2;
    assign cs_fall   = ~cs_p1 & cs_p2;

endmodule

// File: rtl/spi_frame_ctrl.sv
// SPI-slave frame controller: snapshots TX_DATA per chip-select window, shifts it out on MISO,
// shifts MOSI in, and commits RX_DATA only for exact-length frames; a watchdog zeroes the image.
module spi_frame_ctrl
    import spi_frame_pkg::*;
#(
    parameter int FRAME_BITS     = FRAME_BITS_DEF,
    parameter int CNT_W          = CNT_W_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int WD_W           = WD_W_DEF
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic                  SPI_SCLK,
    input  logic                  SPI_CS_N,
    input  logic                  SPI_MOSI,
    output logic                  SPI_MISO,
    input  logic [FRAME_BITS-1:0] TX_DATA,
    output logic [FRAME_BITS-1:0] RX_DATA,
    output logic                  FRAME_VALID,
    output logic                  FRAME_ERR,
    output logic                  LINK_OK,
    output logic                  BUSY,
    output logic [15:0]           FRAME_CNT
);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_OVF  = CNT_W'(FRAME_BITS + 1);
    localparam logic [WD_W-1:0]  WD_MAX   = WD_W'(TIMEOUT_CYCLES - 1);

    function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] v);
        return (v >= CNT_OVF) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [WD_W-1:0] wd_sat_inc(input logic [WD_W-1:0] v);
        return (v >= WD_MAX) ? v : v + WD_W'(1);
    endfunction

    logic mosi_sync, sclk_rise, sclk_fall, cs_rise, cs_fall;

    spi_input_sync u_sync (
        .clk       (CLK),
        .rst_n     (RESET_N),
        .sclk      (SPI_SCLK),
        .cs_n      (SPI_CS_N),
        .mosi      (SPI_MOSI),
        .mosi_sync (mosi_sync),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall),
        .cs_rise   (cs_rise),
        .cs_fall   (cs_fall)
    );

    state_e                state;
    logic [FRAME_BITS-1:0] tx_shreg, rx_shreg, rx_data_q;
    logic [CNT_W-1:0]      bit_cnt;
    logic [WD_W-1:0]       wd_cnt, wd_next;
    logic [15:0]           frame_cnt_q;
    logic                  busy_q, valid_q, err_q, link_ok_q;
    logic                  commit, wd_expire;

    assign commit    = (state == CHECK) && (bit_cnt == CNT_FULL);
    assign wd_next   = wd_sat_inc(wd_cnt);
    assign wd_expire = (wd_next == WD_MAX);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state    <= IDLE;
            tx_shreg <= '0;
            rx_shreg <= '0;
            bit_cnt  <= '0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        tx_shreg <= TX_DATA;
                        bit_cnt  <= '0;
                        busy_q   <= 1'b1;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Chip-select release wins over any SCLK edge seen in the same cycle.
                    if (cs_rise) begin
                        state <= CHECK;
                    end else begin
                        if (sclk_rise) begin
                            rx_shreg <= {rx_shreg[FRAME_BITS-2:0], mosi_sync};
                            bit_cnt  <= cnt_sat_inc(bit_cnt);
                        end
                        if (sclk_fall && (bit_cnt != '0)) begin
                            tx_shreg <= {tx_shreg[FRAME_BITS-2:0], 1'b0};
                        end
                    end
                end
                CHECK: begin
                    valid_q <= commit;
                    err_q   <= ~commit;
                    busy_q  <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A commit in the expiry cycle takes precedence over the watchdog clear.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rx_data_q   <= '0;
            link_ok_q   <= 1'b0;
            wd_cnt      <= '0;
            frame_cnt_q <= '0;
        end else if (commit) begin
            rx_data_q   <= rx_shreg;
            link_ok_q   <= 1'b1;
            wd_cnt      <= '0;
            frame_cnt_q <= frame_cnt_q + 16'd1;
        end else begin
            wd_cnt <= wd_next;
            if (wd_expire) begin
                link_ok_q <= 1'b0;
                rx_data_q <= '0;
            end
        end
    end

    assign SPI_MISO    = (state != IDLE) ? tx_shreg[FRAME_BITS-1] : 1'b0;
    assign RX_DATA     = rx_data_q;
    assign FRAME_VALID = valid_q;
    assign FRAME_ERR   = err_q;
    assign LINK_OK     = link_ok_q;
    assign BUSY        = busy_q;
    assign FRAME_CNT   = frame_cnt_q;

endmodule

// File: tb/tb_spi_frame_ctrl.sv
// Bench for spi_frame_ctrl: a production-timeout instance and a short-timeout instance share stimulus.
// Expected frame outcomes are queued when a frame is sent and popped when the DUT pulses.
module tb_spi_frame_ctrl;

    logic         clk, rst_n, sclk, cs_n, mosi;
    logic [255:0] tx_data;

    logic         miso, frame_valid, frame_err, link_ok, busy;
    logic [255:0] rx_data;
    logic [15:0]  frame_cnt;

    logic         w_miso, w_valid, w_err, w_link_ok, w_busy;
    logic [255:0] w_rx_data;
    logic [15:0]  w_frame_cnt;

    spi_frame_ctrl dut (
        .CLK(clk), .RESET_N(rst_n), .SPI_SCLK(sclk), .SPI_CS_N(cs_n), .SPI_MOSI(mosi),
        .SPI_MISO(miso), .TX_DATA(tx_data), .RX_DATA(rx_data), .FRAME_VALID(frame_valid),
        .FRAME_ERR(frame_err), .LINK_OK(link_ok), .BUSY(busy), .FRAME_CNT(frame_cnt)
    );

    spi_frame_ctrl #(.TIMEOUT_CYCLES(1000)) dut_wd (
        .CLK(clk), .RESET_N(rst_n), .SPI_SCLK(sclk), .SPI_CS_N(cs_n), .SPI_MOSI(mosi),
        .SPI_MISO(w_miso), .TX_DATA(tx_data), .RX_DATA(w_rx_data), .FRAME_VALID(w_valid),
        .FRAME_ERR(w_err), .LINK_OK(w_link_ok), .BUSY(w_busy), .FRAME_CNT(w_frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [255:0] TX_A5    = {32{8'hA5}};
    localparam logic [255:0] PAT_MAIN = {4{64'h0123456789ABCDEF}};
    localparam logic [255:0] PAT_S    = {8{32'hDEADBEEF}};
    localparam logic [255:0] PAT_X    = {16{16'h1234}};
    localparam logic [255:0] PAT_W1   = {16{16'h5A3C}};
    localparam logic [255:0] PAT_W2   = {4{64'hFEDCBA9876543210}};

    typedef struct {
        bit           valid;
        logic [255:0] rx;
        logic [15:0]  cnt;
        logic [255:0] miso;
    } exp_t;

    exp_t         sbq[$];
    exp_t         cur;
    logic [255:0] model_rx;
    logic [15:0]  model_cnt;
    logic [255:0] miso_cap;
    bit           got_valid, got_err;
    int           n_checks = 0;
    int           n_fail   = 0;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives one CS window; rst_bit >= 0 asserts reset at that bit and abandons the frame.
    task automatic send_frame(input int nbits, input logic [255:0] pat, input int chg_bit,
                              input logic [255:0] tx_new, input int rst_bit,
                              output logic [255:0] cap);
        bit aborted = 1'b0;
        cap  = '0;
        cs_n = 1'b0;
        tick(8);
        for (int i = 0; i < nbits; i++) begin
            if (i == rst_bit) begin
                rst_n = 1'b0;
                tick(2);
                cs_n = 1'b1;
                sclk = 1'b0;
                tick(2);
                rst_n = 1'b1;
                aborted = 1'b1;
                break;
            end
            mosi = pat[255 - (i % 256)];
            tick(4);
            if (i < 256) cap[255 - i] = miso;
            if (i == chg_bit) tx_data = tx_new;
            sclk = 1'b1;
            tick(4);
            sclk = 1'b0;
        end
        if (!aborted) begin
            tick(4);
            cs_n = 1'b1;
        end
    endtask

    task automatic wait_pulse(output bit v, output bit e);
        v = 1'b0;
        e = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick(1);
            if (frame_valid || frame_err) begin
                v = frame_valid;
                e = frame_err;
                break;
            end
        end
    endtask

    // Queues the expected outcome, sends the frame and leaves the popped expectation in cur.
    task automatic frame_txn(input int nbits, input logic [255:0] pat, input int chg_bit,
                             input logic [255:0] tx_new);
        exp_t e;
        e.valid = (nbits == 256);
        e.miso  = tx_data;
        if (e.valid) begin
            model_rx  = pat;
            model_cnt = model_cnt + 16'd1;
        end
        e.rx  = model_rx;
        e.cnt = model_cnt;
        sbq.push_back(e);
        send_frame(nbits, pat, chg_bit, tx_new, -1, miso_cap);
        wait_pulse(got_valid, got_err);
        cur = sbq.pop_front();
    endtask

    task automatic test_reset;
        bit seen = 1'b0;
        n_checks++;
        if ({miso, rx_data, frame_valid, frame_err, link_ok, busy, frame_cnt} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rx=%h cnt=%h lo=%b busy=%b", rx_data, frame_cnt, link_ok, busy);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 50; k++) begin
            tick(1);
            if (frame_valid || frame_err || link_ok || busy || miso) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: activity seen=%b required 0", seen);
        end
    endtask

    task automatic test_full_frame;
        tx_data = TX_A5;
        frame_txn(256, PAT_MAIN, -1, '0);
        n_checks++;
        if (miso_cap !== cur.miso) begin
            n_fail++; $display("FAIL full_miso: got %h want %h", miso_cap, cur.miso);
        end
        n_checks++;
        if ({got_valid, got_err} !== {cur.valid, ~cur.valid}) begin
            n_fail++; $display("FAIL full_pulse: got v=%b e=%b want v=%b", got_valid, got_err, cur.valid);
        end
        n_checks++;
        if (rx_data !== cur.rx) begin
            n_fail++; $display("FAIL full_rx: got %h want %h", rx_data, cur.rx);
        end
        n_checks++;
        if (frame_cnt !== cur.cnt || link_ok !== 1'b1) begin
            n_fail++; $display("FAIL full_cnt_link: got cnt=%h lo=%b want cnt=%h lo=1", frame_cnt, link_ok, cur.cnt);
        end
        tick(1);
        n_checks++;
        if ({frame_valid, busy} !== 2'b00) begin
            n_fail++; $display("FAIL full_single_pulse: got v=%b busy=%b want 0 0", frame_valid, busy);
        end
        tick(4);
    endtask

    task automatic test_short_long;
        int errs = 0;
        frame_txn(255, PAT_X, -1, '0);
        if (got_err && !got_valid) errs++;
        tick(4);
        frame_txn(257, PAT_X, -1, '0);
        if (got_err && !got_valid) errs++;
        n_checks++;
        if (errs !== 2) begin
            n_fail++; $display("FAIL shortlong_err_pulses: got %0d want 2", errs);
        end
        n_checks++;
        if (rx_data !== cur.rx || frame_cnt !== cur.cnt) begin
            n_fail++; $display("FAIL shortlong_hold: got rx=%h cnt=%h want rx=%h cnt=%h", rx_data, frame_cnt, cur.rx, cur.cnt);
        end
        tick(4);
    endtask

    task automatic test_tx_snapshot;
        tx_data = '0;
        frame_txn(256, PAT_S, 100, '1);
        n_checks++;
        if (miso_cap !== cur.miso) begin
            n_fail++; $display("FAIL snap_miso: got %h want %h", miso_cap, cur.miso);
        end
        n_checks++;
        if (!got_valid || rx_data !== cur.rx || frame_cnt !== cur.cnt) begin
            n_fail++; $display("FAIL snap_rx: got v=%b rx=%h cnt=%h want rx=%h cnt=%h", got_valid, rx_data, frame_cnt, cur.rx, cur.cnt);
        end
        tx_data = TX_A5;
        tick(4);
    endtask

    task automatic test_watchdog;
        frame_txn(256, PAT_W1, -1, '0);
        n_checks++;
        if ({w_valid, w_link_ok} !== 2'b11 || w_rx_data !== PAT_W1) begin
            n_fail++; $display("FAIL wd_commit: got v=%b lo=%b rx=%h want 1 1 %h", w_valid, w_link_ok, w_rx_data, PAT_W1);
        end
        tick(998);
        n_checks++;
        if (w_link_ok !== 1'b1 || w_rx_data !== PAT_W1) begin
            n_fail++; $display("FAIL wd_before_expiry: got lo=%b rx=%h want 1 %h", w_link_ok, w_rx_data, PAT_W1);
        end
        tick(1);
        n_checks++;
        if (w_link_ok !== 1'b0 || w_rx_data !== '0) begin
            n_fail++; $display("FAIL wd_expiry: got lo=%b rx=%h want 0 0", w_link_ok, w_rx_data);
        end
        n_checks++;
        if (link_ok !== 1'b1 || rx_data !== PAT_W1) begin
            n_fail++; $display("FAIL wd_long_timeout_holds: got lo=%b rx=%h want 1 %h", link_ok, rx_data, PAT_W1);
        end
        frame_txn(256, PAT_W2, -1, '0);
        n_checks++;
        if (w_link_ok !== 1'b1 || w_rx_data !== PAT_W2 || rx_data !== cur.rx) begin
            n_fail++; $display("FAIL wd_restore: got lo=%b rx=%h want 1 %h", w_link_ok, w_rx_data, PAT_W2);
        end
        tick(4);
    endtask

    task automatic test_abort;
        bit seen = 1'b0;
        send_frame(256, PAT_X, -1, '0, 128, miso_cap);
        model_rx  = '0;
        model_cnt = '0;
        for (int k = 0; k < 20; k++) begin
            tick(1);
            if (frame_valid || frame_err || busy || miso) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++; $display("FAIL abort_no_pulse: activity seen=%b required 0", seen);
        end
        n_checks++;
        if (rx_data !== model_rx || frame_cnt !== model_cnt || link_ok !== 1'b0) begin
            n_fail++; $display("FAIL abort_state: got rx=%h cnt=%h lo=%b want 0", rx_data, frame_cnt, link_ok);
        end
    endtask

    task automatic test_cnt_wrap;
        force dut.frame_cnt_q = 16'hFFFF;
        tick(1);
        release dut.frame_cnt_q;
        model_cnt = 16'hFFFF;
        frame_txn(256, PAT_MAIN, -1, '0);
        n_checks++;
        if (got_valid !== 1'b1 || frame_cnt !== cur.cnt || rx_data !== cur.rx) begin
            n_fail++; $display("FAIL cnt_wrap: got v=%b cnt=%h want v=1 cnt=%h", got_valid, frame_cnt, cur.cnt);
        end
        tick(4);
    endtask

    initial begin
        rst_n     = 1'b0;
        cs_n      = 1'b1;
        sclk      = 1'b0;
        mosi      = 1'b0;
        tx_data   = '0;
        model_rx  = '0;
        model_cnt = '0;
        tick(4);
        test_reset;
        test_full_frame;
        test_short_long;
        test_tx_snapshot;
        test_watchdog;
        test_abort;
        test_cnt_wrap;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
